// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_arbiter_if                                                             |
// | Request/response channels of two ALU clients plus the shared ALU32 port.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface alu_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int OPWIDTH = 6
);
    logic               req0_valid;
    logic               req0_ready;
    logic [OPWIDTH-1:0] req0_op;
    logic [WIDTH-1:0]   req0_in1;
    logic [WIDTH-1:0]   req0_in2;
    logic               req1_valid;
    logic               req1_ready;
    logic [OPWIDTH-1:0] req1_op;
    logic [WIDTH-1:0]   req1_in1;
    logic [WIDTH-1:0]   req1_in2;
    logic               rsp0_valid;
    logic               rsp0_ready;
    logic [WIDTH-1:0]   rsp0_data;
    logic               rsp1_valid;
    logic               rsp1_ready;
    logic [WIDTH-1:0]   rsp1_data;
    logic [OPWIDTH-1:0] alu_op;
    logic [WIDTH-1:0]   alu_in1;
    logic [WIDTH-1:0]   alu_in2;
    logic [WIDTH-1:0]   alu_out;

    modport slave (
        input  req0_valid, req0_op, req0_in1, req0_in2,
        input  req1_valid, req1_op, req1_in1, req1_in2,
        output req0_ready, req1_ready,
        input  rsp0_ready, rsp1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output alu_op, alu_in1, alu_in2,
        input  alu_out
    );

    modport master (
        output req0_valid, req0_op, req0_in1, req0_in2,
        output req1_valid, req1_op, req1_in1, req1_in2,
        input  req0_ready, req1_ready,
        output rsp0_ready, rsp1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  alu_op, alu_in1, alu_in2,
        output alu_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_arbiter                                                                |
// | Shares one combinational ALU32 between two requesters, one-entry result   |
// | slot per requester. ALU_ARB_FIXED_PRIO_EN selects fixed priority (req 0). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
    parameter int                 WIDTH   = 32,
    parameter int                 OPWIDTH = 6,
    parameter logic [OPWIDTH-1:0] NOP_OP  = '0
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    logic             w_elig0;
    logic             w_elig1;
    logic             w_grant0;
    logic             w_grant1;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp0_data;
    logic [WIDTH-1:0] r_rsp1_data;

    // A slot being drained this cycle can accept a new result in the same edge.
    assign w_elig0 = bus.req0_valid && (!r_rsp0_valid || bus.rsp0_ready);
    assign w_elig1 = bus.req1_valid && (!r_rsp1_valid || bus.rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_grant0 = w_elig0;
    assign w_grant1 = w_elig1 && !w_elig0;
`else
    logic r_last;

    // r_last names the most recent winner; the other side wins a tie.
    assign w_grant0 = w_elig0 && (!w_elig1 || r_last);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (w_grant0) begin
            r_last <= 1'b0;
        end else if (w_grant1) begin
            r_last <= 1'b1;
        end
    end
`endif

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    always_comb begin
        bus.alu_op  = NOP_OP;
        bus.alu_in1 = '0;
        bus.alu_in2 = '0;
        if (w_grant0) begin
            bus.alu_op  = bus.req0_op;
            bus.alu_in1 = bus.req0_in1;
            bus.alu_in2 = bus.req0_in2;
        end else if (w_grant1) begin
            bus.alu_op  = bus.req1_op;
            bus.alu_in1 = bus.req1_in1;
            bus.alu_in2 = bus.req1_in2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
        end else begin
            if (w_grant0) begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_data  <= bus.alu_out;
            end else if (r_rsp0_valid && bus.rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end
            if (w_grant1) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_data  <= bus.alu_out;
            end else if (r_rsp1_valid && bus.rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp1_data  = r_rsp1_data;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_arbiter                                                             |
// | Directed self-checking bench for alu_arbiter with a behavioural ALU32.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_arbiter;
    localparam logic [5:0] c_nop = 6'd0;
    localparam logic [5:0] c_add = 6'd1;
    localparam logic [5:0] c_sub = 6'd2;
    localparam logic [5:0] c_xor = 6'd3;
    localparam logic [5:0] c_sll = 6'd4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit c_fixed = 1'b1;
`else
    localparam bit c_fixed = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_arbiter_if #(.WIDTH(32), .OPWIDTH(6)) bus ();

    alu_arbiter #(.WIDTH(32), .OPWIDTH(6), .NOP_OP(c_nop)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            c_add:   bus.alu_out = bus.alu_in1 + bus.alu_in2;
            c_sub:   bus.alu_out = bus.alu_in1 - bus.alu_in2;
            c_xor:   bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            c_sll:   bus.alu_out = bus.alu_in1 << bus.alu_in2[4:0];
            default: bus.alu_out = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.req0_valid = 1'b0; bus.req0_op = c_nop; bus.req0_in1 = '0; bus.req0_in2 = '0;
        bus.req1_valid = 1'b0; bus.req1_op = c_nop; bus.req1_in1 = '0; bus.req1_in2 = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
        chk("reset_rsp0_data", bus.rsp0_data, 32'd0);
        chk("reset_rsp1_data", bus.rsp1_data, 32'd0);
        edge1();
        reset = 1'b1;
        edge1();

        // Single ADD on requester 0
        bus.req0_valid = 1'b1; bus.req0_op = c_add;
        bus.req0_in1 = 32'h5; bus.req0_in2 = 32'h3;
        #2;
        chk("add_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        chk("add_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        chk("add_alu_op", {26'b0, bus.alu_op}, {26'b0, c_add});
        chk("add_alu_in1", bus.alu_in1, 32'h5);
        edge1();
        chk("add_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
        chk("add_rsp0_data", bus.rsp0_data, 32'h8);

        // Hold the result, then reset asynchronously mid-cycle
        bus.req0_valid = 1'b0; bus.rsp0_ready = 1'b0;
        edge1();
        chk("hold_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
        chk("hold_rsp0_data", bus.rsp0_data, 32'h8);
        reset = 1'b0;
        #1;
        chk("async_rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
        chk("async_rst_rsp0_data", bus.rsp0_data, 32'd0);
        #1 reset = 1'b1;
        bus.rsp0_ready = 1'b1;
        edge1();

        // Contention: round robin alternates starting with requester 0
        bus.req0_valid = 1'b1; bus.req0_op = c_sub;
        bus.req0_in1 = 32'h0000000A; bus.req0_in2 = 32'h00000001;
        bus.req1_valid = 1'b1; bus.req1_op = c_xor;
        bus.req1_in1 = 32'hFFFF0000; bus.req1_in2 = 32'h0F0F0F0F;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("rr_req0_ready_%0d", i), {31'b0, bus.req0_ready},
                (c_fixed || (i % 2 == 0)) ? 32'd1 : 32'd0);
            chk($sformatf("rr_req1_ready_%0d", i), {31'b0, bus.req1_ready},
                (!c_fixed && (i % 2 == 1)) ? 32'd1 : 32'd0);
            chk($sformatf("rr_alu_op_%0d", i), {26'b0, bus.alu_op},
                (c_fixed || (i % 2 == 0)) ? {26'b0, c_sub} : {26'b0, c_xor});
            edge1();
            chk($sformatf("rr_rsp0_valid_%0d", i), {31'b0, bus.rsp0_valid},
                (c_fixed || (i % 2 == 0)) ? 32'd1 : 32'd0);
            chk($sformatf("rr_rsp1_valid_%0d", i), {31'b0, bus.rsp1_valid},
                (!c_fixed && (i % 2 == 1)) ? 32'd1 : 32'd0);
        end
        chk("rr_rsp0_data", bus.rsp0_data, 32'h00000009);
        chk("rr_rsp1_data", bus.rsp1_data, c_fixed ? 32'h0 : 32'hF0F00F0F);

        // Requester 0 alone moves the pointer to 0, then idle must not touch it
        bus.req1_valid = 1'b0;
        bus.req0_op = c_add; bus.req0_in1 = 32'h1; bus.req0_in2 = 32'h1;
        #2;
        chk("solo_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        edge1();
        chk("solo_rsp0_data", bus.rsp0_data, 32'h2);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("idle_alu_op_%0d", i), {26'b0, bus.alu_op}, {26'b0, c_nop});
            chk($sformatf("idle_alu_in1_%0d", i), bus.alu_in1, 32'd0);
            chk($sformatf("idle_alu_in2_%0d", i), bus.alu_in2, 32'd0);
            chk($sformatf("idle_readies_%0d", i), {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
            edge1();
        end
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #2;
        chk("post_idle_req0_ready", {31'b0, bus.req0_ready}, c_fixed ? 32'd1 : 32'd0);
        chk("post_idle_req1_ready", {31'b0, bus.req1_ready}, c_fixed ? 32'd0 : 32'd1);
        edge1();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        edge1();

        // Backpressure on slot 1
        bus.rsp1_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_op = c_sll;
        bus.req1_in1 = 32'h1; bus.req1_in2 = 32'h4;
        #2;
        chk("bp_first_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
        edge1();
        chk("bp_first_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
        chk("bp_first_rsp1_data", bus.rsp1_data, 32'h00000010);
        bus.req1_op = c_add; bus.req1_in1 = 32'h7; bus.req1_in2 = 32'h8;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk($sformatf("bp_stall_req1_ready_%0d", i), {31'b0, bus.req1_ready}, 32'd0);
            edge1();
            chk($sformatf("bp_stall_rsp1_data_%0d", i), bus.rsp1_data, 32'h00000010);
            chk($sformatf("bp_stall_rsp1_valid_%0d", i), {31'b0, bus.rsp1_valid}, 32'd1);
        end
        bus.rsp1_ready = 1'b1;
        #2;
        chk("bp_release_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
        edge1();
        chk("bp_second_rsp1_data", bus.rsp1_data, 32'h0000000F);
        chk("bp_second_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
        bus.req1_valid = 1'b0;
        edge1();
        chk("bp_drain_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
        chk("bp_drain_rsp1_data", bus.rsp1_data, 32'h0000000F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
